// File: rtl/pam_map.sv
// AXI-stream bytes to PAM2/PAM4 DAC code pairs through a byte FIFO and a symbol shift register.
// Define PAM_MAP_GRAY_EN to use the Gray-coded PAM4 level map instead of natural binary.
module pam_map #(
    parameter int DATA_WIDTH     = 32,
    parameter int PAM_ORDER      = 4,
    parameter int MEM_ADDR_WIDTH = 7,
    parameter int AD_CVER_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [DATA_WIDTH-1:0]        M_AXIS_tdata,
    input  logic                         M_AXIS_tlast,
    input  logic [DATA_WIDTH/8-1:0]      M_AXIS_tkeep,
    input  logic                         M_AXIS_tvalid,
    output logic                         M_AXIS_tready,
    input  logic                         M_out_ready,
    output logic                         M_out_valid,
    output logic [2*AD_CVER_WIDTH-1:0]   M_out_pam_data
);

    localparam int NB             = DATA_WIDTH / 8;
    localparam int DEPTH          = 1 << MEM_ADDR_WIDTH;
    localparam int BPS            = (PAM_ORDER == 2) ? 1 : 2;
    localparam int BEAT_BITS      = 2 * BPS;
    localparam int BEATS_PER_BYTE = 8 / BEAT_BITS;
    localparam int CW             = MEM_ADDR_WIDTH + 1;

    logic [7:0]                mem_q [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [MEM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [7:0]                sh_q, sh_d;
    logic [2:0]                beats_left_q, beats_left_d;
    logic                      out_valid_q, out_valid_d;
    logic [2*AD_CVER_WIDTH-1:0] out_data_q, out_data_d;

    logic                      in_fire;
    logic [NB-1:0]             lane_we;
    logic [MEM_ADDR_WIDTH-1:0] lane_addr [NB];
    logic [CW-1:0]             n_wr;
    logic                      out_load;
    logic                      pop;
    logic                      unused_tlast;

    assign unused_tlast = M_AXIS_tlast;

    function automatic logic [AD_CVER_WIDTH-1:0] level_of(input logic [BPS-1:0] sym);
        logic [1:0] raw;
        logic [1:0] idx;
        longint     full_scale;
        raw = 2'(sym);
`ifdef PAM_MAP_GRAY_EN
        idx = (PAM_ORDER == 4) ? {raw[1], raw[1] ^ raw[0]} : raw;
`else
        idx = raw;
`endif
        full_scale = (longint'(1) << AD_CVER_WIDTH) - longint'(1);
        return AD_CVER_WIDTH'((longint'(idx) * full_scale) / longint'(PAM_ORDER - 1));
    endfunction

    // Gate with reset so the source sees not-ready for the whole time reset is held.
    assign M_AXIS_tready = arst_n && (count_q <= CW'(DEPTH - NB));
    assign in_fire       = M_AXIS_tvalid && M_AXIS_tready;

    // Kept lanes are packed contiguously: each lane's slot is offset by the kept lanes below it.
    always_comb begin
        n_wr = '0;
        for (int k = 0; k < NB; k++) begin
            lane_we[k]   = in_fire && M_AXIS_tkeep[k];
            lane_addr[k] = wr_ptr_q + MEM_ADDR_WIDTH'(n_wr);
            if (lane_we[k]) begin
                n_wr = n_wr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (lane_we[k]) begin
                mem_q[lane_addr[k]] <= M_AXIS_tdata[8*k +: 8];
            end
        end
    end

    assign out_load = (beats_left_q != 3'd0) && (!out_valid_q || M_out_ready);
    assign pop      = (count_q != '0) &&
                      ((beats_left_q == 3'd0) || ((beats_left_q == 3'd1) && out_load));

    always_comb begin
        wr_ptr_d     = wr_ptr_q + MEM_ADDR_WIDTH'(n_wr);
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + n_wr - CW'(pop);
        sh_d         = sh_q;
        beats_left_d = beats_left_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (out_load) begin
            sh_d         = sh_q << BEAT_BITS;
            beats_left_d = beats_left_q - 3'd1;
            out_valid_d  = 1'b1;
            out_data_d   = {level_of(sh_q[7 -: BPS]), level_of(sh_q[7-BPS -: BPS])};
        end else if (M_out_ready) begin
            out_valid_d  = 1'b0;
        end

        // A pop overrides the shift: the old byte's last beat is already in out_data_d.
        if (pop) begin
            sh_d         = mem_q[rd_ptr_q];
            beats_left_d = 3'(BEATS_PER_BYTE);
            rd_ptr_d     = rd_ptr_q + MEM_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sh_q         <= '0;
            beats_left_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sh_q         <= sh_d;
            beats_left_q <= beats_left_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign M_out_valid    = out_valid_q;
    assign M_out_pam_data = out_data_q;

endmodule

// File: tb/tb_pam_map.sv
// Directed bench for pam_map (default parameters): vector table, latency, reset and streaming checks.
// Expected codes follow the Gray map when PAM_MAP_GRAY_EN is defined.
module tb_pam_map;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] M_AXIS_tdata = '0;
    logic        M_AXIS_tlast = 1'b0;
    logic [3:0]  M_AXIS_tkeep = '0;
    logic        M_AXIS_tvalid = 1'b0;
    logic        M_AXIS_tready;
    logic        M_out_ready = 1'b0;
    logic        M_out_valid;
    logic [23:0] M_out_pam_data;

    int tests_run = 0;
    int tests_failed = 0;

    pam_map dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tlast   (M_AXIS_tlast),
        .M_AXIS_tkeep   (M_AXIS_tkeep),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tready  (M_AXIS_tready),
        .M_out_ready    (M_out_ready),
        .M_out_valid    (M_out_valid),
        .M_out_pam_data (M_out_pam_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic [3:0]       keep;
        int               n_beats;
        logic [7:0][23:0] beats;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVector(input logic [31:0] d, input logic [3:0] k, input int n,
                             input logic [23:0] b0 = 0, input logic [23:0] b1 = 0,
                             input logic [23:0] b2 = 0, input logic [23:0] b3 = 0,
                             input logic [23:0] b4 = 0, input logic [23:0] b5 = 0,
                             input logic [23:0] b6 = 0, input logic [23:0] b7 = 0);
        vec_t v;
        v.data = d;
        v.keep = k;
        v.n_beats = n;
        v.beats = {b7, b6, b5, b4, b3, b2, b1, b0};
        vecs.push_back(v);
    endtask

    task automatic doReset();
        M_AXIS_tvalid = 1'b0;
        M_out_ready = 1'b0;
        arst_n = 1'b0;
        #3;
        checkOutput("reset tready", M_AXIS_tready, 0);
        checkOutput("reset valid", M_out_valid, 0);
        checkOutput("reset data", M_out_pam_data, 0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
    endtask

    // Send one word, then collect every beat with ready held high.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic [23:0] got [8];
        int n_got;
        bit accepted;
        for (int i = 0; i < 8; i++) got[i] = '0;
        M_out_ready = 1'b1;
        M_AXIS_tdata = v.data;
        M_AXIS_tkeep = v.keep;
        M_AXIS_tvalid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 10 && !accepted; c++) begin
            if (M_AXIS_tready) accepted = 1'b1;
            tick();
        end
        M_AXIS_tvalid = 1'b0;
        checkOutput({tag, " accept"}, 32'(accepted), 1);
        n_got = 0;
        for (int c = 0; c < 24; c++) begin
            if (M_out_valid) begin
                if (n_got < 8) got[n_got] = M_out_pam_data;
                n_got++;
            end
            tick();
        end
        checkOutput({tag, " beat count"}, 32'(n_got), 32'(v.n_beats));
        for (int i = 0; i < v.n_beats; i++) begin
            checkOutput($sformatf("%s beat %0d", tag, i), 32'(got[i]), 32'(v.beats[i]));
        end
    endtask

    function automatic logic [31:0] streamWord(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [3:0] streamKeep(input int i);
        logic [3:0] tab [8];
        tab = '{4'hF, 4'h1, 4'h0, 4'hE, 4'h5, 4'hA, 4'h8, 4'hF};
        return tab[i % 8];
    endfunction

    // Level code back to the 2-bit symbol it encodes; returns 0 in bad for unknown codes.
    function automatic logic [1:0] codeToSym(input logic [11:0] code, output bit ok);
        logic [1:0] idx;
        ok = 1'b1;
        case (code)
            12'h000: idx = 2'd0;
            12'h555: idx = 2'd1;
            12'hAAA: idx = 2'd2;
            12'hFFF: idx = 2'd3;
            default: begin idx = 2'd0; ok = 1'b0; end
        endcase
`ifdef PAM_MAP_GRAY_EN
        return {idx[1], idx[1] ^ idx[0]};
`else
        return idx;
`endif
    endfunction

    task automatic runStream(input int n_words, input bit toggle_valid, input bit toggle_ready, input string tag);
        logic [7:0]  exp_q[$];
        logic [7:0]  acc;
        logic [23:0] prev_data;
        logic [8:0]  exp_byte;
        int word_idx, acc_n, cycle;
        bit prev_hold, saw_low, done, ok_hi, ok_lo;
        word_idx = 0; acc_n = 0; cycle = 0; acc = '0;
        prev_hold = 1'b0; prev_data = '0; saw_low = 1'b0; done = 1'b0;
        while (cycle < 20000 && !done) begin
            if (prev_hold) begin
                checkOutput({tag, " hold valid"}, 32'(M_out_valid), 1);
                checkOutput({tag, " hold data"}, 32'(M_out_pam_data), 32'(prev_data));
            end
            if (word_idx < n_words && (!toggle_valid || ((cycle / 4) % 2 == 0))) begin
                M_AXIS_tvalid = 1'b1;
                M_AXIS_tdata = streamWord(word_idx);
                M_AXIS_tkeep = streamKeep(word_idx);
            end else begin
                M_AXIS_tvalid = 1'b0;
            end
            if (!M_AXIS_tready) saw_low = 1'b1;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                for (int k = 0; k < 4; k++)
                    if (M_AXIS_tkeep[k]) exp_q.push_back(M_AXIS_tdata[8*k +: 8]);
                word_idx++;
            end
            M_out_ready = !toggle_ready || ((cycle / 4) % 2 == 0);
            if (M_out_valid && M_out_ready) begin
                acc = {acc[3:0], codeToSym(M_out_pam_data[23:12], ok_hi), codeToSym(M_out_pam_data[11:0], ok_lo)};
                checkOutput({tag, " level code"}, 32'(ok_hi && ok_lo), 1);
                acc_n += 2;
                if (acc_n == 4) begin
                    exp_byte = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
                    checkOutput({tag, " byte"}, 32'(acc), 32'(exp_byte));
                    acc_n = 0;
                end
            end
            prev_hold = M_out_valid && !M_out_ready;
            prev_data = M_out_pam_data;
            cycle++;
            tick();
            done = (word_idx == n_words) && (exp_q.size() == 0) && (acc_n == 0) && !M_out_valid;
        end
        M_AXIS_tvalid = 1'b0;
        checkOutput({tag, " completed"}, 32'(done), 1);
        if (toggle_ready) checkOutput({tag, " tready dropped"}, 32'(saw_low), 1);
        M_out_ready = 1'b1;
        ok_hi = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (M_out_valid) ok_hi = 1'b0;
            tick();
        end
        checkOutput({tag, " tail idle"}, 32'(ok_hi), 1);
    endtask

    initial begin
        vec_t v;
        bit idle;

`ifdef PAM_MAP_GRAY_EN
        addVector(32'h0000_00B4, 4'b0001, 2, 24'hFFFAAA, 24'h555000);
        addVector(32'h1B00_0000, 4'b1000, 2, 24'h000555, 24'hFFFAAA);
        addVector(32'hFF11_FF00, 4'b1110, 6, 24'hAAAAAA, 24'hAAAAAA, 24'h000555, 24'h000555,
                  24'hAAAAAA, 24'hAAAAAA);
        addVector(32'h00C9_3600, 4'b0110, 4, 24'h000AAA, 24'h555FFF, 24'hAAA000, 24'hFFF555);
`else
        addVector(32'h1234_5600, 4'b1111, 8, 24'h000000, 24'h000000, 24'h555555, 24'h555AAA,
                  24'h000FFF, 24'h555000, 24'h000555, 24'h000AAA);
        addVector(32'hFF11_FF00, 4'b1110, 6, 24'hFFFFFF, 24'hFFFFFF, 24'h000555, 24'h000555,
                  24'hFFFFFF, 24'hFFFFFF);
        addVector(32'hA5C3_0F96, 4'b0101, 4, 24'hAAA555, 24'h555AAA, 24'hFFF000, 24'h000FFF);
        addVector(32'h0000_00B4, 4'b0001, 2, 24'hAAAFFF, 24'h555000);
        addVector(32'h1B00_0000, 4'b1000, 2, 24'h000555, 24'hAAAFFF);
        addVector(32'h00C9_3600, 4'b0110, 4, 24'h000FFF, 24'h555AAA, 24'hFFF000, 24'hAAA555);
`endif
        addVector(32'hDEAD_BEEF, 4'b0000, 0);

        #2;
        doReset();

        // Latency from the accepting edge to the first valid beat.
        M_out_ready = 1'b1;
        M_AXIS_tdata = 32'h1234_5600;
        M_AXIS_tkeep = 4'b1111;
        M_AXIS_tvalid = 1'b1;
        checkOutput("tready after reset", 32'(M_AXIS_tready), 1);
        tick();
        M_AXIS_tvalid = 1'b0;
        checkOutput("latency edge+0 valid", 32'(M_out_valid), 0);
        tick();
        checkOutput("latency edge+1 valid", 32'(M_out_valid), 0);
        tick();
        checkOutput("latency edge+2 valid", 32'(M_out_valid), 1);
        checkOutput("latency first beat", 32'(M_out_pam_data), 0);
        for (int c = 0; c < 12; c++) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-stream reset: buffered bytes and the in-flight beat vanish at once.
        v = vecs[0];
        M_out_ready = 1'b1;
        M_AXIS_tdata = 32'hFFFF_FFFF;
        M_AXIS_tkeep = 4'b1111;
        M_AXIS_tvalid = 1'b1;
        tick();
        tick();
        M_AXIS_tvalid = 1'b0;
        tick();
        tick();
        checkOutput("pre-reset valid", 32'(M_out_valid), 1);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("async reset valid", 32'(M_out_valid), 0);
        checkOutput("async reset data", 32'(M_out_pam_data), 0);
        checkOutput("async reset tready", 32'(M_AXIS_tready), 0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        idle = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (M_out_valid) idle = 1'b0;
            tick();
        end
        checkOutput("no stale beat after reset", 32'(idle), 1);
        v.data = 32'h0000_0055;
        v.keep = 4'b0001;
        v.n_beats = 2;
        v.beats = '0;
        v.beats[0] = 24'h555555;
        v.beats[1] = 24'h555555;
        applyStimulus(v, "post-reset");

        runStream(500, 1'b0, 1'b1, "backpressure");
        runStream(40, 1'b1, 1'b0, "valid-toggle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
